// File: rtl/ro_puf_pkg.sv
// ro_puf_pkg
//   Shared definitions for the ring-oscillator PUF measurement engine:
//   the measurement FSM state encoding, a width helper that never returns
//   zero, and the elaboration-time parameter legality test.
package ro_puf_pkg;

  // Measurement sequence: ARM clears the race counters, COUNT runs one
  // window, CMP records a vote / writes a bit, DONE publishes the response.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    COUNT = 3'd2,
    CMP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Bits needed to index n items; at least 1 so single-entry cases still
  // get a legal vector.
  function automatic int clog2_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  // NUM_RO must be a power of two (pair indices wrap by truncation) and at
  // least 4; VOTES must be odd so the majority is never split; WINDOW >= 2.
  function automatic bit params_ok(input int num_ro, input int votes,
                                   input int window);
    return is_pow2(num_ro) && (num_ro >= 4) && (votes >= 1) &&
           ((votes % 2) == 1) && (window >= 2);
  endfunction

endpackage

// File: rtl/ro_puf_engine_if.sv
// ro_puf_engine_if
//   Control/status bundle between a host (tt_um wrapper, serial front end,
//   testbench) and ro_puf_engine.
//   master : drives ena, start, abort, challenge; observes busy, done,
//            response and the debug state.
//   slave  : the engine.
//
// Handshake: a request is accepted on a rising edge where the engine is
// idle and ena & start & ~abort is high; challenge is captured on that same
// edge. busy is high from the next cycle through the done cycle inclusive,
// and start is ignored whenever busy is high. done is a single-cycle pulse
// during which response already holds the new value; response then stays
// stable until the next done. abort cancels any non-idle activity on the
// next edge without a done pulse and without touching response.
interface ro_puf_engine_if #(
  parameter int CHAL_W = 3,
  parameter int RESP_W = 8
);
  logic                 ena;
  logic                 start;
  logic                 abort;
  logic [CHAL_W-1:0]    challenge;
  logic                 busy;
  logic                 done;
  logic [RESP_W-1:0]    response;
  ro_puf_pkg::state_t   state;     // debug view of the measurement FSM

  modport master (
    output ena, start, abort, challenge,
    input  busy, done, response, state
  );

  modport slave (
    input  ena, start, abort, challenge,
    output busy, done, response, state
  );
endinterface

// File: rtl/ro_sync_edge.sv
// ro_sync_edge
//   Brings one free-running ring-oscillator output into the clk domain with
//   a 2-flop synchroniser and flags each rising edge for one clk cycle.
//   clk    : sampling clock
//   reset  : synchronous, active-high; clears the synchroniser chain
//   ro_i   : raw RO output, asynchronous to clk
//   edge_o : one-cycle pulse per synchronised rising edge of ro_i
module ro_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic ro_i,
  output logic edge_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= ro_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // s3 is only a delayed copy of the settled s2 for edge detection.
  assign edge_o = s2_q & ~s3_q;

endmodule

// File: rtl/ro_puf_engine.sv
// ro_puf_engine
//   Ring-oscillator PUF measurement engine. For each response bit i it races
//   RO a = (challenge + 2i) mod NUM_RO against RO b = a + 1 over WINDOW clk
//   cycles, repeats VOTES times, and takes a majority of "a counted more
//   edges than b".
//   clk    : sole clock, rising edge
//   reset  : synchronous, active-high; clears all state including response
//   ro_in  : NUM_RO raw RO outputs, asynchronous to clk
//   bus    : control/status bundle (slave side), see ro_puf_engine_if
module ro_puf_engine #(
  parameter int NUM_RO = 8,
  parameter int RESP_W = 8,
  parameter int CNT_W  = 12,
  parameter int WINDOW = 256,
  parameter int VOTES  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_RO-1:0] ro_in,
  ro_puf_engine_if.slave    bus
);
  import ro_puf_pkg::*;

  localparam int CHAL_W = clog2_w(NUM_RO);
  localparam int BIDX_W = clog2_w(RESP_W);
  localparam int VIDX_W = clog2_w(VOTES);
  localparam int ONES_W = clog2_w(VOTES + 1);
  localparam int WIN_W  = clog2_w(WINDOW);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (!params_ok(NUM_RO, VOTES, WINDOW)) begin : g_bad_params
    $error("ro_puf_engine: NUM_RO must be a power of two >= 4, VOTES odd, WINDOW >= 2");
  end

  // ---------------------------------------------------------------------
  // Per-RO synchroniser + edge detector, free-running in every state
  // ---------------------------------------------------------------------
  logic [NUM_RO-1:0] ro_edge;

  for (genvar j = 0; j < NUM_RO; j++) begin : g_sync
    ro_sync_edge u_sync (
      .clk    (clk),
      .reset  (reset),
      .ro_i   (ro_in[j]),
      .edge_o (ro_edge[j])
    );
  end

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [CHAL_W-1:0]   chal_q, chal_d;
  logic [BIDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [VIDX_W-1:0]   vote_idx_q, vote_idx_d;
  logic [ONES_W-1:0]   ones_q, ones_d;
  logic [WIN_W-1:0]    win_q, win_d;
  logic [CNT_W-1:0]    cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0]    cnt_b_q, cnt_b_d;
  logic [RESP_W-1:0]   shadow_q, shadow_d;
  logic [RESP_W-1:0]   response_q, response_d;

  // ---------------------------------------------------------------------
  // Decode helpers
  // ---------------------------------------------------------------------
  logic              accept;
  logic [CHAL_W-1:0] sel_a, sel_b;
  logic              win_last, last_vote, last_bit;
  logic              vote_one, bit_val;
  logic [ONES_W-1:0] ones_total;
  logic [RESP_W-1:0] shadow_next;

  assign accept = (state_q == IDLE) & bus.ena & bus.start & ~bus.abort;

  // Pair selection wraps by truncation to CHAL_W bits.
  assign sel_a = chal_q + CHAL_W'({bit_idx_q, 1'b0});
  assign sel_b = sel_a + CHAL_W'(1);

  assign win_last   = (win_q == WIN_W'(WINDOW - 1));
  assign last_vote  = (vote_idx_q == VIDX_W'(VOTES - 1));
  assign last_bit   = (bit_idx_q == BIDX_W'(RESP_W - 1));
  assign vote_one   = (cnt_a_q > cnt_b_q);   // a tie votes 0
  assign ones_total = ones_q + ONES_W'(vote_one);
  assign bit_val    = (ones_total > ONES_W'(VOTES / 2));

  always_comb begin
    shadow_next            = shadow_q;
    shadow_next[bit_idx_q] = bit_val;
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------
  // FSM: next state (abort overrides every transition)
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ARM;
      ARM:     state_d = COUNT;
      COUNT:   if (win_last) state_d = CMP;
      CMP:     state_d = (last_vote && last_bit) ? DONE : ARM;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.abort) state_d = IDLE;
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    bus.busy = (state_q != IDLE);
    bus.done = (state_q == DONE);
  end

  assign bus.response = response_q;
  assign bus.state    = state_q;

  // ---------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------
  always_comb begin
    chal_d     = chal_q;
    bit_idx_d  = bit_idx_q;
    vote_idx_d = vote_idx_q;
    ones_d     = ones_q;
    win_d      = win_q;
    cnt_a_d    = cnt_a_q;
    cnt_b_d    = cnt_b_q;
    shadow_d   = shadow_q;
    response_d = response_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          chal_d     = bus.challenge;
          bit_idx_d  = '0;
          vote_idx_d = '0;
          ones_d     = '0;
          shadow_d   = '0;
        end
      end
      ARM: begin
        // Edges seen here (including late ones from the previous window
        // still in the synchroniser) are discarded.
        win_d   = '0;
        cnt_a_d = '0;
        cnt_b_d = '0;
      end
      COUNT: begin
        win_d = win_q + WIN_W'(1);
        if (ro_edge[sel_a] && (cnt_a_q != CNT_MAX)) cnt_a_d = cnt_a_q + CNT_W'(1);
        if (ro_edge[sel_b] && (cnt_b_q != CNT_MAX)) cnt_b_d = cnt_b_q + CNT_W'(1);
      end
      CMP: begin
        if (!last_vote) begin
          vote_idx_d = vote_idx_q + VIDX_W'(1);
          ones_d     = ones_total;
        end else begin
          vote_idx_d = '0;
          ones_d     = '0;
          shadow_d   = shadow_next;
          if (!last_bit) begin
            bit_idx_d = bit_idx_q + BIDX_W'(1);
          end else if (!bus.abort) begin
            // Published on the edge into DONE so response is already valid
            // while done is high.
            response_d = shadow_next;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chal_q     <= '0;
      bit_idx_q  <= '0;
      vote_idx_q <= '0;
      ones_q     <= '0;
      win_q      <= '0;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      shadow_q   <= '0;
      response_q <= '0;
    end else begin
      chal_q     <= chal_d;
      bit_idx_q  <= bit_idx_d;
      vote_idx_q <= vote_idx_d;
      ones_q     <= ones_d;
      win_q      <= win_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
      shadow_q   <= shadow_d;
      response_q <= response_d;
    end
  end

endmodule
